bin2bcd_seq: RTL and testbench

- Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 8-digit seven-segment scanner and drives its 32-bit data input.
- Counters and results therefore show in decimal instead of hex.
- Holds the last result stable on its output so the display never shows intermediate values.

---
 rtl/bin2bcd_seq.sv | 121 ++++++++++++
 tb/tb_bin2bcd_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter (double dabble, one bit per clock).
// Optional macro BIN2BCD_OVF_HEX_EN: on overflow output raw hex instead of all 9s.
module bin2bcd_seq #(
   parameter int IN_W   = 27,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IN_W-1:0]       in_data,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  done,
   output logic                  ovf
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int WW    = IN_W + BCD_W;
   localparam int CNT_W = $clog2(IN_W + 1);

   function automatic logic [63:0] pow10_m1(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p - 64'd1;
   endfunction

   localparam logic [63:0] MAXV = pow10_m1(DIGITS);

   // Every BCD nibble >= 5 gets +3 so the following shift carries correctly.
   function automatic logic [WW-1:0] add3(input logic [WW-1:0] w);
      logic [WW-1:0] r;
      r = w;
      for (int d = 0; d < DIGITS; d++) begin
         if (r[IN_W+4*d +: 4] >= 4'd5) r[IN_W+4*d +: 4] = r[IN_W+4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t              r_state, w_state_nxt;
   logic [WW-1:0]       r_work;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ovf_pend;
   logic                w_accept, w_finish;
   logic [WW-1:0]       w_shift;
   logic [63:0]         w_in_ext;
   logic [BCD_W-1:0]    w_sat;

   assign in_ready = (r_state == S_IDLE);
   assign w_shift  = add3(r_work) << 1;
   assign w_in_ext = 64'(in_data);

`ifdef BIN2BCD_OVF_HEX_EN
   logic [IN_W-1:0]     r_raw;
   logic [WW-1:0]       w_raw_ext;
   assign w_raw_ext = WW'(r_raw);
   assign w_sat     = w_raw_ext[BCD_W-1:0];

   always_ff @(posedge clk) begin
      if (reset)         r_raw <= '0;
      else if (w_accept) r_raw <= in_data;
   end
`else
   assign w_sat = {DIGITS{4'h9}};
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Result registers only change on the final shift, so bcd never shows partial values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_work     <= '0;
         r_cnt      <= '0;
         r_ovf_pend <= 1'b0;
         bcd        <= '0;
         ovf        <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= w_finish;
         if (w_accept) begin
            r_work     <= {{BCD_W{1'b0}}, in_data};
            r_cnt      <= CNT_W'(IN_W);
            r_ovf_pend <= (w_in_ext > MAXV);
         end else if (r_state == S_SHIFT) begin
            r_work <= w_shift;
            r_cnt  <= r_cnt - CNT_W'(1);
         end
         if (w_finish) begin
            bcd <= r_ovf_pend ? w_sat : w_shift[WW-1:IN_W];
            ovf <= r_ovf_pend;
         end
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: expected results queued at accept, checked on done.
module tb_bin2bcd_seq;

   localparam int IN_W   = 27;
   localparam int DIGITS = 8;
   localparam int BW     = 4 * DIGITS;
   localparam logic [63:0] MAXV = 64'd99999999;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [IN_W-1:0]   in_data = '0;
   logic [BW-1:0]     bcd;
   logic              done;
   logic              ovf;

   always #5 clk = ~clk;

   bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .bcd      (bcd),
      .done     (done),
      .ovf      (ovf)
   );

   typedef struct {
      logic [BW-1:0] b;
      logic          o;
      int            acc;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   int            last_done = 0;
   int            done_gap = 0;
   logic [BW-1:0] last_bcd = '0;
   logic          last_ovf = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [BW-1:0] ref_bcd(input logic [63:0] v);
      logic [BW-1:0] r;
      logic [63:0]   t;
      r = '0;
      t = v;
      if (v > MAXV) begin
`ifdef BIN2BCD_OVF_HEX_EN
         r = v[BW-1:0];
`else
         r = {DIGITS{4'h9}};
`endif
      end else begin
         for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(t % 64'd10);
            t = t / 64'd10;
         end
      end
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      logic ok;
      if (reset) begin
         q.delete();
         last_bcd = '0;
         last_ovf = 1'b0;
      end else begin
         if (done) begin
            if (q.size() == 0) begin
               check_val("spurious_done", 64'(done), 64'd0);
            end else begin
               e = q.pop_front();
               check_val("bcd", 64'(bcd), 64'(e.b));
               check_val("ovf", 64'(ovf), 64'(e.o));
               check_val("latency", 64'(cyc - e.acc), 64'(IN_W));
               if (!ovf) begin
                  ok = 1'b1;
                  for (int d = 0; d < DIGITS; d++) if (bcd[4*d +: 4] > 4'd9) ok = 1'b0;
                  check_val("digit", 64'(ok), 64'd1);
               end
               done_gap  = cyc - last_done;
               last_done = cyc;
               last_bcd  = bcd;
               last_ovf  = ovf;
            end
         end else begin
            check_val("hold_bcd", 64'(bcd), 64'(last_bcd));
            check_val("hold_ovf", 64'(ovf), 64'(last_ovf));
         end
         check_val("in_ready", 64'(in_ready), 64'(q.size() == 0));
         if (in_valid && in_ready)
            q.push_back('{ref_bcd(64'(in_data)), (64'(in_data) > MAXV), cyc + 1});
      end
   end

   task automatic convert(input logic [IN_W-1:0] v);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check_val("ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = IN_W'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) check_val("idle_timeout", 64'(q.size()), 64'd0);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_val("rst_bcd", 64'(bcd), 64'd0);
      check_val("rst_ovf", 64'(ovf), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_ready", 64'(in_ready), 64'd1);

      convert(IN_W'(0));
      convert(IN_W'(12345678));
      convert(IN_W'(99999999));
      convert(IN_W'(100000000));
      convert(IN_W'((1 << IN_W) - 1));
      convert(IN_W'(5));
      wait_idle();

      // Back-to-back: hold 7 through SHIFT, present 42 in the done cycle.
      in_valid = 1'b1;
      in_data  = IN_W'(7);
      @(posedge clk); #1;
      repeat (IN_W) begin
         @(posedge clk); #1;
      end
      in_data = IN_W'(42);
      @(posedge clk); #1;
      for (int k = 0; k < IN_W - 2; k++) begin
         in_valid = k[0];
         in_data  = IN_W'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_idle();
      check_val("b2b_gap", 64'(done_gap), 64'(IN_W + 1));

      // Reset in the middle of a conversion.
      convert(IN_W'(87654321));
      repeat (9) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_val("abort_ready", 64'(in_ready), 64'd1);
      check_val("abort_bcd", 64'(bcd), 64'd0);
      check_val("abort_ovf", 64'(ovf), 64'd0);
      check_val("abort_done", 64'(done), 64'd0);
      repeat (40) begin
         @(posedge clk); #1;
      end

      for (int i = 0; i < 2500; i++)
         convert(IN_W'($urandom_range(0, (1 << IN_W) - 1)));
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
